acumulador_productos: RTL and testbench
=======================================

Name: acumulador_productos

Overview:
- Downstream stage of the 2-bit multiplier (`multiplicador`). Its 4-bit product output `m_o` feeds this block.
- Accumulates a group of N_TERMS products into a wider running sum with valid/ready input handshake.
- Presents the completed sum on a valid/ready output handshake, with a sticky overflow flag.
- Used for dot-product / MAC-style tests on top of the combinational multiplier.

Parameters:
- PROD_W, 4, width of the incoming product; matches multiplier result width.
- N_TERMS, 4, number of products summed per group; legal range ≥ 1.
- ACC_W, 6, accumulator and sum width; must satisfy ACC_W ≥ PROD_W.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- prod_i  input  PROD_W  product from multiplier `m_o`; unsigned.
- prod_valid_i  input  1  prod_i holds a valid product.
- prod_ready_o  output  1  block accepts prod_i this cycle.
- clear_i  input  1  synchronous abort of the current group.
- sum_o  output  ACC_W  completed group sum; unsigned, wraps modulo 2^ACC_W.
- sum_valid_o  output  1  sum_o valid.
- sum_ready_i  input  1  consumer takes sum_o.
- ovf_o  output  1  sticky flag: the current/presented group overflowed ACC_W.
- count_o  output  $clog2(N_TERMS+1)  products accepted in the current group.

Behaviour:
- Reset (rst_i=1 at edge, highest priority, any state): state=ACUM, acc=0, count_o=0, sum_o=0, sum_valid_o=0, ovf_o=0.
- States: ACUM, ENTREGA. No other states.
- prod_ready_o = (state==ACUM) & ~clear_i. This is combinational; it is the only combinational input-to-output path.
- Accept = prod_valid_i & prod_ready_o. Handling of an accepted product in ACUM:
  - Zero-extend prod_i to ACC_W+1 bits and add to acc; acc takes the low ACC_W bits.
  - If the carry bit is set, ovf_o <= 1 (sticky).
  - count_o increments.
- Transition ACUM -> ENTREGA: on accept when count_o == N_TERMS-1.
  - On that edge: sum_o <= acc + prod_i (wrapped), sum_valid_o <= 1, count_o <= N_TERMS, acc <= 0.
  - Latency: sum_valid_o is high the cycle after the last product is accepted.
- prod_valid_i low in ACUM: hold all state.
- ENTREGA:
  - prod_ready_o=0.
  - sum_o, ovf_o and sum_valid_o are held stable until sum_valid_o & sum_ready_i.
  - On that edge: sum_valid_o <= 0, count_o <= 0, ovf_o <= 0, state <= ACUM.
  - The next group's first product can be accepted on the following cycle. Minimum group period is N_TERMS+1 cycles.
- clear_i (below rst_i, any state):
  - acc <= 0, count_o <= 0, ovf_o <= 0, sum_valid_o <= 0, state <= ACUM. sum_o keeps its last value.
  - An in-flight prod_i is not accepted, because prod_ready_o is low.
  - clear_i and sum_ready_i in the same ENTREGA cycle: the clear wins; the result counts as dropped.
- N_TERMS=1: every accepted product goes directly to ENTREGA.
- Upstream must hold prod_i stable while prod_valid_i=1 and not accepted. Valid is not dropped without acceptance.
- sum_valid_o never depends combinationally on sum_ready_i.

Test Plan:
- Reset then idle: rst_i high 2 cycles -> sum_o=0, sum_valid_o=0, ovf_o=0, count_o=0, prod_ready_o=1.
- Back-to-back group, defaults: products 1,4,6,9 on consecutive cycles -> cycle after the 4th, sum_o=20, sum_valid_o=1, ovf_o=0, count_o=4, prod_ready_o=0; sum_ready_i=1 -> next cycle sum_valid_o=0, count_o=0.
- Backpressure/bubbles: products 2,3,3,1 with prod_valid_i gaps; sum_ready_i low 5 cycles -> sum_o=9 held stable, prod_ready_o=0 throughout; a fifth product presented is not accepted until after the handshake.
- Overflow, ACC_W=5: products 9,9,9,9 -> sum_o=4 (36 mod 32), ovf_o=1 while presented; the next group 1,1,1,1 -> sum_o=4, ovf_o=0.
- Clear mid-group: accept 9,9, then clear_i=1 with prod_valid_i=1 -> product not accepted, count_o=0; group 1,2,3,0 -> sum_o=6, ovf_o=0.
- Reset/clear in ENTREGA: a group is presented with sum_ready_i=0, then rst_i (or clear_i with sum_ready_i=1) -> sum_valid_o=0 next cycle, state ACUM, prod_ready_o=1. Randomized 2-bit operands via the multiplier, checked against a scoreboard of sum mod 2^ACC_W.

Source files
------------

// File: rtl/acumulador_productos.sv
// Sums groups of N_TERMS unsigned products into an ACC_W-bit total, with a sticky overflow flag per group.
// The sum is valid the cycle after the last product. While the sum waits for sum_ready_i, no new products are taken.
module acumulador_productos #(
  parameter int PROD_W  = 4,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [PROD_W-1:0]            prod_i,
  input  logic                         prod_valid_i,
  output logic                         prod_ready_o,
  input  logic                         clear_i,
  output logic [ACC_W-1:0]             sum_o,
  output logic                         sum_valid_o,
  input  logic                         sum_ready_i,
  output logic                         ovf_o,
  output logic [$clog2(N_TERMS+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  typedef enum logic {ACUM, ENTREGA} state_t;

  state_t           state_q, state_nxt;
  logic [ACC_W-1:0] acc_q, acc_nxt;
  logic [ACC_W-1:0] sum_q, sum_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic             ovf_q, ovf_nxt;
  logic             accept;
  logic [ACC_W:0]   sum_ext;

  assign prod_ready_o = (state_q == ACUM) & ~clear_i;
  assign accept       = prod_valid_i & prod_ready_o;
  // The extra top bit is the carry out of ACC_W bits. It drives the overflow flag.
  assign sum_ext      = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};

  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    sum_nxt   = sum_q;
    count_nxt = count_q;
    ovf_nxt   = ovf_q;
    if (clear_i) begin
      state_nxt = ACUM;
      acc_nxt   = '0;
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state_q)
        ACUM: begin
          if (accept) begin
            if (sum_ext[ACC_W]) ovf_nxt = 1'b1;
            if (count_q == CNT_W'(N_TERMS - 1)) begin
              sum_nxt   = sum_ext[ACC_W-1:0];
              count_nxt = CNT_W'(N_TERMS);
              acc_nxt   = '0;
              state_nxt = ENTREGA;
            end else begin
              acc_nxt   = sum_ext[ACC_W-1:0];
              count_nxt = count_q + CNT_W'(1);
            end
          end
        end
        ENTREGA: begin
          if (sum_ready_i) begin
            state_nxt = ACUM;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: state_nxt = ACUM;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACUM;
      acc_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      acc_q   <= acc_nxt;
      sum_q   <= sum_nxt;
      count_q <= count_nxt;
      ovf_q   <= ovf_nxt;
    end
  end

  // The sum is valid exactly when the block is in ENTREGA, so no separate flop is kept for it.
  assign sum_valid_o = (state_q == ENTREGA);
  assign sum_o       = sum_q;
  assign ovf_o       = ovf_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_acumulador_productos.sv
// Bench that drives two accumulators (ACC_W=6 and ACC_W=5) from the same inputs.
// Expected group sums go into a queue when a group completes and are compared at each output handshake.
module tb_acumulador_productos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] prod = '0;
  logic       prod_valid = 1'b0;
  logic       clear = 1'b0;
  logic       sum_ready = 1'b0;

  logic       rdy_d, vld_d, ovf_d;
  logic [5:0] sum_d;
  logic [2:0] cnt_d;
  logic       rdy_o, vld_o, ovf_o5;
  logic [4:0] sum_o5;
  logic [2:0] cnt_o;

  always #5 clk = ~clk;

  acumulador_productos dut_d (
    .clk_i(clk), .rst_i(rst), .prod_i(prod), .prod_valid_i(prod_valid),
    .prod_ready_o(rdy_d), .clear_i(clear), .sum_o(sum_d), .sum_valid_o(vld_d),
    .sum_ready_i(sum_ready), .ovf_o(ovf_d), .count_o(cnt_d)
  );

  acumulador_productos #(.PROD_W(4), .N_TERMS(4), .ACC_W(5)) dut_o (
    .clk_i(clk), .rst_i(rst), .prod_i(prod), .prod_valid_i(prod_valid),
    .prod_ready_o(rdy_o), .clear_i(clear), .sum_o(sum_o5), .sum_valid_o(vld_o),
    .sum_ready_i(sum_ready), .ovf_o(ovf_o5), .count_o(cnt_o)
  );

  typedef struct {
    int s6;
    int o6;
    int s5;
    int o5;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int acc6 = 0, acc5 = 0, ovf6 = 0, ovf5 = 0, cnt = 0;
  int last6 = 0, last5 = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_add(input int p);
    exp_t e;
    acc6 += p;
    if (acc6 >= 64) begin ovf6 = 1; acc6 -= 64; end
    acc5 += p;
    if (acc5 >= 32) begin ovf5 = 1; acc5 -= 32; end
    cnt++;
    if (cnt == 4) begin
      e.s6 = acc6; e.o6 = ovf6; e.s5 = acc5; e.o5 = ovf5;
      q.push_back(e);
      acc6 = 0; acc5 = 0; ovf6 = 0; ovf5 = 0; cnt = 0;
    end
  endtask

  task automatic model_clear();
    exp_t e;
    acc6 = 0; acc5 = 0; ovf6 = 0; ovf5 = 0; cnt = 0;
    if (q.size() > 0) begin
      e = q.pop_front();
      last6 = e.s6;
      last5 = e.s5;
    end
  endtask

  task automatic model_reset();
    acc6 = 0; acc5 = 0; ovf6 = 0; ovf5 = 0; cnt = 0;
    q.delete();
    last6 = 0; last5 = 0;
  endtask

  task automatic send(input int p, input int gap);
    bit ok;
    ok = 1'b0;
    prod = 4'(p);
    prod_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_d) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("send_timeout", 0, 1);
      prod_valid = 1'b0;
      return;
    end
    chk("rdy_pair", rdy_o, 1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    model_add(p);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic take(input int wait_n);
    bit ok;
    exp_t e;
    ok = 1'b0;
    sum_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vld_d) begin ok = 1'b1; break; end
    end
    if (!ok) begin chk("take_timeout", 0, 1); return; end
    if (q.size() == 0) begin chk("sb_empty", 0, 1); return; end
    e = q[0];
    for (int i = 0; i < wait_n; i++) begin
      chk("hold_sum6", sum_d, e.s6);
      chk("hold_sum5", sum_o5, e.s5);
      chk("hold_vld5", vld_o, 1);
      chk("hold_rdy", rdy_d, 0);
      chk("hold_cnt", cnt_d, 4);
      @(negedge clk);
    end
    sum_ready = 1'b1;
    chk("sum6", sum_d, e.s6);
    chk("ovf6", ovf_d, e.o6);
    chk("sum5", sum_o5, e.s5);
    chk("ovf5", ovf_o5, e.o5);
    chk("vld5", vld_o, 1);
    chk("cnt_full", cnt_d, 4);
    chk("rdy_ent", rdy_d, 0);
    @(posedge clk); #1;
    sum_ready = 1'b0;
    e = q.pop_front();
    last6 = e.s6;
    last5 = e.s5;
    @(negedge clk);
    chk("post_vld6", vld_d, 0);
    chk("post_vld5", vld_o, 0);
    chk("post_cnt", cnt_d, 0);
    chk("post_ovf5", ovf_o5, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sum", sum_d, 0);
    chk("rst_vld", vld_d, 0);
    chk("rst_ovf", ovf_d, 0);
    chk("rst_cnt", cnt_d, 0);
    chk("rst_rdy", rdy_d, 1);
    @(posedge clk); #1;

    // back-to-back group, then latency check
    send(1, 0); send(4, 0); send(6, 0); send(9, 0);
    @(negedge clk);
    chk("lat_vld", vld_d, 1);
    chk("lat_sum", sum_d, 20);
    take(0);

    // bubbles, long backpressure, fifth product waiting behind the handshake
    @(posedge clk); #1;
    send(2, 1); send(3, 2); send(3, 0); send(1, 3);
    prod = 4'd5;
    prod_valid = 1'b1;
    take(5);
    chk("p5_rdy", rdy_d, 1);
    @(posedge clk); #1;
    prod_valid = 1'b0;
    model_add(5);
    @(negedge clk);
    chk("p5_cnt", cnt_d, 1);
    @(posedge clk); #1;
    send(0, 0); send(0, 0); send(0, 0);
    take(1);

    // overflow on the 5-bit instance, then a clean group
    @(posedge clk); #1;
    send(9, 0); send(9, 0); send(9, 0); send(9, 0);
    take(2);
    @(posedge clk); #1;
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    take(0);

    // abort mid-group with a product in flight
    @(posedge clk); #1;
    send(9, 0); send(9, 0);
    prod = 4'd7;
    prod_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    chk("clr_rdy", rdy_d, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    prod_valid = 1'b0;
    model_clear();
    @(negedge clk);
    chk("clr_cnt", cnt_d, 0);
    chk("clr_ovf", ovf_d, 0);
    @(posedge clk); #1;
    send(1, 0); send(2, 0); send(3, 0); send(0, 0);
    take(0);

    // reset while a sum is presented
    @(posedge clk); #1;
    send(2, 0); send(2, 0); send(2, 0); send(2, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rent_vld", vld_d, 0);
    chk("rent_rdy", rdy_d, 1);
    chk("rent_sum", sum_d, 0);
    chk("rent_cnt", cnt_d, 0);

    // clear beats sum_ready in ENTREGA; sum_o keeps the dropped value
    @(posedge clk); #1;
    send(3, 0); send(3, 0); send(3, 0); send(3, 0);
    @(negedge clk);
    chk("cent_pre", vld_d, 1);
    clear = 1'b1;
    sum_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    sum_ready = 1'b0;
    model_clear();
    @(negedge clk);
    chk("cent_vld", vld_d, 0);
    chk("cent_rdy", rdy_d, 1);
    chk("cent_cnt", cnt_d, 0);
    chk("cent_sum6", sum_d, last6);
    chk("cent_sum5", sum_o5, last5);

    // random 2-bit x 2-bit products
    @(posedge clk); #1;
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 4; k++) begin
        int a, b;
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        send(a * b, int'($urandom_range(0, 2)));
      end
      take(int'($urandom_range(0, 3)));
      @(posedge clk); #1;
    end

    chk("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
